l2_mshr_alloc: RTL and testbench
================================

Name: l2_mshr_alloc

Overview:
MSHR allocator and free-list manager for the L2 Spandex controller. It is the producer side of the MSHR occupancy bookkeeping: it hands out free MSHR indices to the request path and reclaims them on completion. It emits the add_mshr_entry / incr_mshr_cnt pulses consumed by the L2 register block, and sequences fence/drain by blocking allocation until every entry has retired.

Parameters:
N_MSHR, 4, number of MSHR entries (matches `N_MSHR)
MSHR_BITS, $clog2(N_MSHR), index width (matches `MSHR_BITS; `MSHR_BITS_P1 = MSHR_BITS+1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
alloc_req  in  1  request path wants an MSHR entry
alloc_ready  out  1  allocation possible this cycle
alloc_idx  out  MSHR_BITS  index granted when alloc_req && alloc_ready
free_valid  in  1  an entry retires this cycle
free_idx  in  MSHR_BITS  index being retired
fence_req  in  1  single-cycle pulse: start fence/drain
fence_done  out  1  single-cycle pulse: all entries retired after fence_req
busy_vec  out  N_MSHR  bit i = entry i allocated
mshr_cnt  out  MSHR_BITS+1  count of free entries
add_mshr_entry  out  1  net-allocate pulse to l2_regs
incr_mshr_cnt  out  1  net-free pulse to l2_regs
err_double_free  out  1  sticky: free of a non-busy entry

Behaviour:
- Reset (rst==0 at posedge clk): busy_vec=0, mshr_cnt=N_MSHR, state=IDLE, fence_done=0, err_double_free=0. Reset overrides everything, including a fence in progress; no fence_done is emitted for an aborted fence.
- alloc_ready = (mshr_cnt != 0) && (state == IDLE). Combinational from registered state only.
- alloc_idx = lowest-numbered 0 bit of the current registered busy_vec. Combinational. Don't-care when mshr_cnt == 0.
- alloc_fire = alloc_req && alloc_ready. On the next edge, busy_vec[alloc_idx] <= 1.
- free_fire = free_valid && busy_vec[free_idx]. On the next edge, busy_vec[free_idx] <= 0.
- free_valid with busy_vec[free_idx]==0: no state change; err_double_free <= 1, cleared only by reset.
- Same-cycle alloc_fire and free_fire:
  - Both apply and mshr_cnt is unchanged.
  - The index being freed is not eligible for this cycle's grant; allocation selects from the pre-edge busy_vec.
- mshr_cnt: -1 on alloc_fire only; +1 on free_fire only; unchanged on both or neither. It never underflows (alloc blocked at 0) and never exceeds N_MSHR (free requires busy).
- Pulses to l2_regs (combinational, same cycle as the fire):
  - add_mshr_entry = alloc_fire && !free_fire
  - incr_mshr_cnt = free_fire && !alloc_fire
  - Because both are suppressed on coincidence, l2_regs' add-over-incr priority cannot diverge from this block's count.
  - Invariant: l2_regs mshr_cnt == this block's mshr_cnt every cycle.
- FSM (IDLE, DRAIN, DONE):
  - IDLE: on fence_req, go to DRAIN if busy_vec != 0 (after this cycle's updates), else go to DONE. alloc_fire in the fence_req cycle is still honoured, since alloc_ready was high.
  - DRAIN: allocation blocked; frees proceed. Go to DONE on the edge where next busy_vec == 0.
  - DONE: fence_done = 1 for exactly this cycle (registered state decode); go to IDLE. Allocation is still blocked in DONE.
  - fence_req outside IDLE is ignored.
- Latency:
  - Grant is visible on busy_vec and mshr_cnt 1 cycle after the fire.
  - Fence with an empty MSHR: fence_done 1 cycle after fence_req.
  - Fence with entries outstanding: fence_done 1 cycle after the last free_fire edge.

Decomposition:
- l2_mshr_alloc_state_t (IDLE/DRAIN/DONE) goes in the shared spandex_types package.
- N_MSHR, MSHR_BITS and MSHR_BITS_P1 continue to come from spandex_consts.
- One natural sub-module: l2_prio_enc_free, a parameterised lowest-zero-bit finder (in: N_MSHR vector; out: index, any_free).

Test Plan:
- Reset then four alloc_req cycles → alloc_idx 0,1,2,3; busy_vec 4'b1111; mshr_cnt 0; alloc_ready 0; add_mshr_entry high on all four.
- Full, then free_idx=2 → mshr_cnt 1, incr_mshr_cnt pulse, next alloc_idx=2.
- busy_vec=4'b0011, alloc_req && free_valid(idx 0) same cycle → alloc_idx=2, busy_vec=4'b0110, mshr_cnt stays 2, neither pulse asserted.
- free_valid idx=3 while busy_vec[3]=0 → busy_vec and mshr_cnt unchanged; err_double_free=1 and stays 1 until reset.
- busy_vec=4'b0101, fence_req → alloc_ready 0; free 0 then free 2 → fence_done pulses once, the cycle after the second free edge; alloc_ready 1 the cycle after that. Fence with busy_vec=0 → fence_done 1 cycle after fence_req.
- rst=0 during DRAIN → next cycle busy_vec=0, mshr_cnt=4, state IDLE, fence_done never asserted.

Source files
------------

// File: rtl/l2_mshr_alloc_pkg.sv
// Shared constants and state type for the L2 MSHR allocator.
// The MSHR count and index widths must agree with the L2 register block.
package l2_mshr_alloc_pkg;

  localparam int N_MSHR       = 4;
  localparam int MSHR_BITS    = $clog2(N_MSHR);
  localparam int MSHR_BITS_P1 = MSHR_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } l2_mshr_alloc_state_t;

endpackage

// File: rtl/l2_mshr_alloc_prio_enc_free.sv
// Finds the lowest-numbered clear bit of a busy vector.
// Also reports whether any clear bit exists.
module l2_prio_enc_free #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] busy,
  output logic [W-1:0] idx,
  output logic         any_free
);

  // Scanning from the top down leaves the lowest clear bit as the final value.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx      = W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_mshr_alloc.sv
// MSHR allocator / free-list manager for the L2 Spandex controller.
// Hands out free MSHR indices, reclaims them on retire, and sequences fence/drain.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | normal operation; allocation allowed when an entry is free
//  ST_DRAIN | fence pending; allocation blocked, frees still accepted
//  ST_DONE  | all entries retired; fence_done pulses; allocation blocked
module l2_mshr_alloc
  import l2_mshr_alloc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_ready,
  output logic [MSHR_BITS-1:0] alloc_idx,
  input  logic                 free_valid,
  input  logic [MSHR_BITS-1:0] free_idx,
  input  logic                 fence_req,
  output logic                 fence_done,
  output logic [N_MSHR-1:0]    busy_vec,
  output logic [MSHR_BITS:0]   mshr_cnt,
  output logic                 add_mshr_entry,
  output logic                 incr_mshr_cnt,
  output logic                 err_double_free
);

  localparam logic [MSHR_BITS:0] CNT_ONE  = MSHR_BITS_P1'(1);
  localparam logic [MSHR_BITS:0] CNT_FULL = MSHR_BITS_P1'(N_MSHR);

  l2_mshr_alloc_state_t state_q, state_d;
  logic [N_MSHR-1:0]    busy_q, busy_d;
  logic [MSHR_BITS:0]   cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [MSHR_BITS-1:0] enc_idx;
  logic                 enc_any_free;
  logic                 alloc_fire;
  logic                 free_fire;
  logic                 free_hit;

  l2_prio_enc_free #(
    .N (N_MSHR),
    .W (MSHR_BITS)
  ) u_prio_enc_free (
    .busy     (busy_q),
    .idx      (enc_idx),
    .any_free (enc_any_free)
  );

  always_comb begin
    free_hit       = busy_q[free_idx];
    alloc_ready    = (cnt_q != '0) && (state_q == ST_IDLE);
    alloc_idx      = enc_idx;
    alloc_fire     = alloc_req && alloc_ready;
    free_fire      = free_valid && free_hit;
    add_mshr_entry = alloc_fire && !free_fire;
    incr_mshr_cnt  = free_fire && !alloc_fire;
    fence_done     = (state_q == ST_DONE);
  end

  // The freed entry is busy pre-edge, so it can never collide with the grant.
  always_comb begin
    busy_d = busy_q;
    if (alloc_fire) busy_d[alloc_idx] = 1'b1;
    if (free_fire)  busy_d[free_idx]  = 1'b0;

    cnt_d = cnt_q;
    if (add_mshr_entry)     cnt_d = cnt_q - CNT_ONE;
    else if (incr_mshr_cnt) cnt_d = cnt_q + CNT_ONE;

    err_d = err_q | (free_valid && !free_hit);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fence_req) state_d = (busy_d != '0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        if (busy_d == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= '0;
      cnt_q   <= CNT_FULL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_vec        = busy_q;
  assign mshr_cnt        = cnt_q;
  assign err_double_free = err_q;

  logic unused_any_free;
  assign unused_any_free = enc_any_free;

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Self-checking bench for l2_mshr_alloc: directed vector table, reset-abort
// sequence, then randomized traffic against a behavioural model.
module tb_l2_mshr_alloc;
  import l2_mshr_alloc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 alloc_req;
  logic                 alloc_ready;
  logic [MSHR_BITS-1:0] alloc_idx;
  logic                 free_valid;
  logic [MSHR_BITS-1:0] free_idx;
  logic                 fence_req;
  logic                 fence_done;
  logic [N_MSHR-1:0]    busy_vec;
  logic [MSHR_BITS:0]   mshr_cnt;
  logic                 add_mshr_entry;
  logic                 incr_mshr_cnt;
  logic                 err_double_free;

  always #5 clk = ~clk;

  l2_mshr_alloc dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_idx       (alloc_idx),
    .free_valid      (free_valid),
    .free_idx        (free_idx),
    .fence_req       (fence_req),
    .fence_done      (fence_done),
    .busy_vec        (busy_vec),
    .mshr_cnt        (mshr_cnt),
    .add_mshr_entry  (add_mshr_entry),
    .incr_mshr_cnt   (incr_mshr_cnt),
    .err_double_free (err_double_free)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a set of occupied entries, a sticky error flag, and a
  // fence phase (0 = none, 1 = waiting for entries to retire, 2 = reporting done).
  bit m_busy[N_MSHR];
  bit m_err;
  int m_fence;

  function automatic int m_free_count();
    int n = 0;
    foreach (m_busy[i]) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_lowest_free();
    foreach (m_busy[i]) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w = '0;
    foreach (m_busy[i]) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_err   = 1'b0;
    m_fence = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check state.
  task automatic cycle(input bit a, input bit fv, input int fi, input bit fr);
    bit exp_ready, af, ff, any_left;
    int low;
    alloc_req  = a;
    free_valid = fv;
    free_idx   = MSHR_BITS'(fi);
    fence_req  = fr;
    #1;
    exp_ready = (m_free_count() > 0) && (m_fence == 0);
    low       = m_lowest_free();
    af        = a && exp_ready;
    ff        = fv && m_busy[fi];
    chk("alloc_ready", alloc_ready, exp_ready);
    if (low >= 0) chk("alloc_idx", alloc_idx, low);
    chk("add_mshr_entry", add_mshr_entry, af && !ff);
    chk("incr_mshr_cnt", incr_mshr_cnt, ff && !af);
    chk("fence_done_comb", fence_done, m_fence == 2);

    if (fv && !m_busy[fi]) m_err = 1'b1;
    if (ff) m_busy[fi] = 1'b0;
    if (af) m_busy[low] = 1'b1;
    any_left = (m_free_count() != N_MSHR);
    if (m_fence == 0)      begin if (fr) m_fence = any_left ? 1 : 2; end
    else if (m_fence == 1) begin if (!any_left) m_fence = 2; end
    else                   m_fence = 0;

    @(posedge clk);
    #1;
    chk("busy_vec", busy_vec, m_busy_word());
    chk("mshr_cnt", mshr_cnt, m_free_count());
    chk("err_double_free", err_double_free, m_err);
    chk("fence_done", fence_done, m_fence == 2);
  endtask

  typedef struct {
    bit a; bit fv; int fi; bit fr;
    bit rdy; int idx; bit add; bit incr;
    int busy; int cnt; bit done; bit err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b0; alloc_req = 0; free_valid = 0; free_idx = '0; fence_req = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_cnt", mshr_cnt, N_MSHR);
    chk("rst_done", fence_done, 0);
    chk("rst_err", err_double_free, 0);
    chk("rst_ready", alloc_ready, 1);
    rst = 1'b1;

    //            a fv fi fr  rdy idx add incr  busy    cnt done err
    tbl.push_back('{1,0,0,0,  1,  0, 1, 0,    4'b0001, 3, 0, 0});
    tbl.push_back('{1,0,0,0,  1,  1, 1, 0,    4'b0011, 2, 0, 0});
    tbl.push_back('{1,0,0,0,  1,  2, 1, 0,    4'b0111, 1, 0, 0});
    tbl.push_back('{1,0,0,0,  1,  3, 1, 0,    4'b1111, 0, 0, 0});
    tbl.push_back('{1,0,0,0,  0, -1, 0, 0,    4'b1111, 0, 0, 0});
    tbl.push_back('{0,1,2,0,  0, -1, 0, 1,    4'b1011, 1, 0, 0});
    tbl.push_back('{1,0,0,0,  1,  2, 1, 0,    4'b1111, 0, 0, 0});
    tbl.push_back('{0,1,2,0,  0, -1, 0, 1,    4'b1011, 1, 0, 0});
    tbl.push_back('{0,1,3,0,  1,  2, 0, 1,    4'b0011, 2, 0, 0});
    tbl.push_back('{1,1,0,0,  1,  2, 0, 0,    4'b0110, 2, 0, 0});
    tbl.push_back('{0,1,3,0,  1,  0, 0, 0,    4'b0110, 2, 0, 1});
    tbl.push_back('{0,1,1,0,  1,  0, 0, 1,    4'b0100, 3, 0, 1});
    tbl.push_back('{1,0,0,0,  1,  0, 1, 0,    4'b0101, 2, 0, 1});
    tbl.push_back('{0,0,0,1,  1,  1, 0, 0,    4'b0101, 2, 0, 1});
    tbl.push_back('{1,0,0,0,  0,  1, 0, 0,    4'b0101, 2, 0, 1});
    tbl.push_back('{0,1,0,0,  0,  1, 0, 1,    4'b0100, 3, 0, 1});
    tbl.push_back('{0,1,2,0,  0,  0, 0, 1,    4'b0000, 4, 1, 1});
    tbl.push_back('{1,0,0,0,  0,  0, 0, 0,    4'b0000, 4, 0, 1});
    tbl.push_back('{1,0,0,0,  1,  0, 1, 0,    4'b0001, 3, 0, 1});
    tbl.push_back('{0,1,0,0,  1,  1, 0, 1,    4'b0000, 4, 0, 1});
    tbl.push_back('{0,0,0,1,  1,  0, 0, 0,    4'b0000, 4, 1, 1});
    tbl.push_back('{0,0,0,0,  0,  0, 0, 0,    4'b0000, 4, 0, 1});

    @(posedge clk); #1;
    foreach (tbl[k]) begin
      alloc_req  = tbl[k].a;
      free_valid = tbl[k].fv;
      free_idx   = MSHR_BITS'(tbl[k].fi);
      fence_req  = tbl[k].fr;
      #1;
      chk($sformatf("vec%0d_ready", k), alloc_ready, tbl[k].rdy);
      if (tbl[k].idx >= 0) chk($sformatf("vec%0d_idx", k), alloc_idx, tbl[k].idx);
      chk($sformatf("vec%0d_add", k), add_mshr_entry, tbl[k].add);
      chk($sformatf("vec%0d_incr", k), incr_mshr_cnt, tbl[k].incr);
      cycle(tbl[k].a, tbl[k].fv, tbl[k].fi, tbl[k].fr);
      chk($sformatf("vec%0d_busy", k), busy_vec, tbl[k].busy);
      chk($sformatf("vec%0d_cnt", k), mshr_cnt, tbl[k].cnt);
      chk($sformatf("vec%0d_done", k), fence_done, tbl[k].done);
      chk($sformatf("vec%0d_err", k), err_double_free, tbl[k].err);
    end

    // Reset in the middle of a drain aborts the fence without a done pulse.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("drain_ready_blocked", alloc_ready, 0);
    rst = 1'b0; alloc_req = 0; free_valid = 0; fence_req = 0;
    @(posedge clk); #1;
    chk("abort_busy", busy_vec, 0);
    chk("abort_cnt", mshr_cnt, N_MSHR);
    chk("abort_done", fence_done, 0);
    chk("abort_err", err_double_free, 0);
    rst = 1'b1;
    m_reset();
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);

    // Randomized traffic with occasional fences and resets.
    for (int n = 0; n < 3000; n++) begin
      bit a, fv, fr;
      int fi;
      int pick;
      int busy_list[$];
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0; alloc_req = 0; free_valid = 0; fence_req = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_reset();
        chk("rnd_rst_cnt", mshr_cnt, N_MSHR);
      end
      busy_list.delete();
      foreach (m_busy[i]) if (m_busy[i]) busy_list.push_back(i);
      a  = ($urandom_range(0, 9) < 5);
      fv = ($urandom_range(0, 9) < 4);
      fr = ($urandom_range(0, 39) == 0);
      if (busy_list.size() > 0 && $urandom_range(0, 7) != 0) begin
        pick = $urandom_range(0, busy_list.size() - 1);
        fi   = busy_list[pick];
      end else begin
        fi = $urandom_range(0, N_MSHR - 1);
      end
      cycle(a, fv, fi, fr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
